// File: rtl/ysyx_23060025_lsu_wb_buf.sv
// ysyx_23060025_lsu_wb_buf: DEPTH-entry elastic FIFO carrying the write-back payload from LSU to WB.
// Latency: a push is visible at the head one cycle later (no bypass); sustains 1 entry/cycle.
// Backpressure: t_lsu_ready_o drops only when full and is driven from registered count only;
//   f_flush_i empties the buffer and drops any payload offered in that cycle.
// Ports:
//   clock, reset          - clock and asynchronous active-high reset
//   f_lsu_*_i / t_lsu_ready_o - LSU side valid/ready handshake and payload fields
//   t_wb_*_o / f_wb_ready_i   - WB side head entry, valid/ready handshake
//   f_flush_i             - discard all buffered entries
//   t_wb_count_o          - number of occupied entries
module ysyx_23060025_lsu_wb_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  f_lsu_valid_i,
  output logic                  t_lsu_ready_o,
  input  logic                  f_lsu_reg_wen_i,
  input  logic [4:0]            f_lsu_wreg_i,
  input  logic [DATA_WIDTH-1:0] f_lsu_reg_wdata_i,
  input  logic [DATA_WIDTH-1:0] f_lsu_csr_wdata_i,
  input  logic [2:0]            f_lsu_csr_type_i,
  input  logic                  f_lsu_memory_inst_i,
  input  logic                  f_lsu_ebreak_flag_i,
  input  logic                  f_flush_i,
  output logic                  t_wb_valid_o,
  input  logic                  f_wb_ready_i,
  output logic                  t_wb_reg_wen_o,
  output logic [4:0]            t_wb_wreg_o,
  output logic [DATA_WIDTH-1:0] t_wb_reg_wdata_o,
  output logic [DATA_WIDTH-1:0] t_wb_csr_wdata_o,
  output logic [2:0]            t_wb_csr_type_o,
  output logic                  t_wb_memory_inst_o,
  output logic                  t_wb_ebreak_flag_o,
  output logic [CNT_W-1:0]      t_wb_count_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 2 * DATA_WIDTH + 11;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               push;
  logic               pop;

  // Ready comes from the registered count only, so a full buffer refuses a
  // push even if WB pops in the same cycle; this keeps f_wb_ready_i off the
  // LSU timing path.
  assign t_lsu_ready_o = (cnt_q != CNT_W'(DEPTH));
  assign t_wb_valid_o  = (cnt_q != '0);
  assign push          = f_lsu_valid_i & t_lsu_ready_o;
  assign pop           = t_wb_valid_o & f_wb_ready_i;

  assign wr_entry = {f_lsu_reg_wen_i, f_lsu_wreg_i, f_lsu_reg_wdata_i,
                     f_lsu_csr_wdata_i, f_lsu_csr_type_i,
                     f_lsu_memory_inst_i, f_lsu_ebreak_flag_i};

  // Storage is never cleared, so stale entries must be masked when empty to
  // keep write enables and ebreak from asserting without valid.
  assign head_entry = t_wb_valid_o ? mem_q[rd_ptr_q] : '0;

  assign {t_wb_reg_wen_o, t_wb_wreg_o, t_wb_reg_wdata_o,
          t_wb_csr_wdata_o, t_wb_csr_type_o,
          t_wb_memory_inst_o, t_wb_ebreak_flag_o} = head_entry;

  assign t_wb_count_o = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (f_flush_i) begin
      // Flush dominates any handshake in the same cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset: entries are only observable once counted.
  always_ff @(posedge clock) begin
    if (push && !f_flush_i) mem_q[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: tb/tb_ysyx_23060025_lsu_wb_buf.sv
module tb_ysyx_23060025_lsu_wb_buf;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clock;
  logic          reset;
  logic          f_lsu_valid_i;
  logic          t_lsu_ready_o;
  logic          f_lsu_reg_wen_i;
  logic [4:0]    f_lsu_wreg_i;
  logic [DW-1:0] f_lsu_reg_wdata_i;
  logic [DW-1:0] f_lsu_csr_wdata_i;
  logic [2:0]    f_lsu_csr_type_i;
  logic          f_lsu_memory_inst_i;
  logic          f_lsu_ebreak_flag_i;
  logic          f_flush_i;
  logic          t_wb_valid_o;
  logic          f_wb_ready_i;
  logic          t_wb_reg_wen_o;
  logic [4:0]    t_wb_wreg_o;
  logic [DW-1:0] t_wb_reg_wdata_o;
  logic [DW-1:0] t_wb_csr_wdata_o;
  logic [2:0]    t_wb_csr_type_o;
  logic          t_wb_memory_inst_o;
  logic          t_wb_ebreak_flag_o;
  logic [CW-1:0] t_wb_count_o;

  int errors = 0;
  int checks = 0;

  ysyx_23060025_lsu_wb_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock               (clock),
    .reset               (reset),
    .f_lsu_valid_i       (f_lsu_valid_i),
    .t_lsu_ready_o       (t_lsu_ready_o),
    .f_lsu_reg_wen_i     (f_lsu_reg_wen_i),
    .f_lsu_wreg_i        (f_lsu_wreg_i),
    .f_lsu_reg_wdata_i   (f_lsu_reg_wdata_i),
    .f_lsu_csr_wdata_i   (f_lsu_csr_wdata_i),
    .f_lsu_csr_type_i    (f_lsu_csr_type_i),
    .f_lsu_memory_inst_i (f_lsu_memory_inst_i),
    .f_lsu_ebreak_flag_i (f_lsu_ebreak_flag_i),
    .f_flush_i           (f_flush_i),
    .t_wb_valid_o        (t_wb_valid_o),
    .f_wb_ready_i        (f_wb_ready_i),
    .t_wb_reg_wen_o      (t_wb_reg_wen_o),
    .t_wb_wreg_o         (t_wb_wreg_o),
    .t_wb_reg_wdata_o    (t_wb_reg_wdata_o),
    .t_wb_csr_wdata_o    (t_wb_csr_wdata_o),
    .t_wb_csr_type_o     (t_wb_csr_type_o),
    .t_wb_memory_inst_o  (t_wb_memory_inst_o),
    .t_wb_ebreak_flag_o  (t_wb_ebreak_flag_o),
    .t_wb_count_o        (t_wb_count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer a generic payload; csr_wdata is the complement of reg_wdata so both
  // data fields can be cross-checked at the output.
  task automatic offer(input logic v, input logic [DW-1:0] d);
    f_lsu_valid_i       = v;
    f_lsu_reg_wen_i     = 1'b1;
    f_lsu_wreg_i        = d[4:0];
    f_lsu_reg_wdata_i   = d;
    f_lsu_csr_wdata_i   = ~d;
    f_lsu_csr_type_i    = 3'b010;
    f_lsu_memory_inst_i = 1'b0;
    f_lsu_ebreak_flag_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    f_flush_i = 1'b0;
    f_wb_ready_i = 1'b0;
    offer(1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (t_lsu_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", t_lsu_ready_o); end
    checks++;
    if (t_wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", t_wb_valid_o); end
    checks++;
    if (t_wb_count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", t_wb_count_o); end
    checks++;
    if ({t_wb_reg_wen_o, t_wb_wreg_o, t_wb_reg_wdata_o, t_wb_csr_wdata_o, t_wb_csr_type_o,
         t_wb_memory_inst_o, t_wb_ebreak_flag_o} !== 75'd0) begin
      errors++; $display("FAIL reset_payload: got wdata=%h wen=%b wreg=%0d expected all zero",
                         t_wb_reg_wdata_o, t_wb_reg_wen_o, t_wb_wreg_o);
    end
  endtask

  task automatic test_single();
    f_wb_ready_i        = 1'b1;
    f_lsu_valid_i       = 1'b1;
    f_lsu_reg_wen_i     = 1'b1;
    f_lsu_wreg_i        = 5'd5;
    f_lsu_reg_wdata_i   = 32'hDEADBEEF;
    f_lsu_csr_wdata_i   = 32'h12345678;
    f_lsu_csr_type_i    = 3'b101;
    f_lsu_memory_inst_i = 1'b1;
    f_lsu_ebreak_flag_i = 1'b1;
    tick();
    offer(1'b0, 32'h0);
    checks++;
    if (t_wb_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", t_wb_valid_o); end
    checks++;
    if ({t_wb_reg_wen_o, t_wb_wreg_o, t_wb_reg_wdata_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_gpr: got wen=%b wreg=%0d wdata=%h expected 1/5/deadbeef",
                         t_wb_reg_wen_o, t_wb_wreg_o, t_wb_reg_wdata_o);
    end
    checks++;
    if ({t_wb_csr_wdata_o, t_wb_csr_type_o, t_wb_memory_inst_o, t_wb_ebreak_flag_o} !==
        {32'h12345678, 3'b101, 1'b1, 1'b1}) begin
      errors++; $display("FAIL single_csr: got csr=%h type=%b mem=%b ebreak=%b expected 12345678/101/1/1",
                         t_wb_csr_wdata_o, t_wb_csr_type_o, t_wb_memory_inst_o, t_wb_ebreak_flag_o);
    end
    tick();
    checks++;
    if ({t_wb_valid_o, t_wb_count_o, t_wb_reg_wen_o, t_wb_ebreak_flag_o} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL single_after: got valid=%b count=%0d wen=%b ebreak=%b expected 0/0/0/0",
                         t_wb_valid_o, t_wb_count_o, t_wb_reg_wen_o, t_wb_ebreak_flag_o);
    end
  endtask

  task automatic test_fill_drain();
    f_wb_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      offer(1'b1, i);
      tick();
      checks++;
      if (t_wb_count_o !== CW'(i)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", t_wb_count_o, i); end
      checks++;
      if (t_lsu_ready_o !== (i < 4)) begin errors++; $display("FAIL fill_ready: got %b expected %b after %0d pushes", t_lsu_ready_o, (i < 4), i); end
    end
    // Fifth push offered while full must be refused.
    offer(1'b1, 32'd99);
    tick();
    offer(1'b0, 32'h0);
    checks++;
    if (t_wb_count_o !== 3'd4) begin errors++; $display("FAIL fill_overflow: got count %0d expected 4", t_wb_count_o); end
    f_wb_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if ({t_wb_valid_o, t_wb_reg_wdata_o, t_wb_csr_wdata_o} !== {1'b1, 32'(i), ~32'(i)}) begin
        errors++; $display("FAIL drain_data: got valid=%b wdata=%0d expected 1/%0d", t_wb_valid_o, t_wb_reg_wdata_o, i);
      end
      checks++;
      if (t_lsu_ready_o !== (i != 1)) begin errors++; $display("FAIL drain_ready: got %b expected %b before pop %0d", t_lsu_ready_o, (i != 1), i); end
      tick();
    end
    f_wb_ready_i = 1'b0;
    checks++;
    if ({t_wb_valid_o, t_wb_count_o} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL drain_empty: got valid=%b count=%0d expected 0/0", t_wb_valid_o, t_wb_count_o);
    end
  endtask

  task automatic test_back_to_back();
    f_wb_ready_i = 1'b0;
    offer(1'b1, 32'd100);
    tick();
    offer(1'b1, 32'd101);
    tick();
    f_wb_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      offer(1'b1, 32'(102 + k));
      checks++;
      if (t_wb_reg_wdata_o !== 32'(100 + k)) begin errors++; $display("FAIL b2b_order: got %0d expected %0d", t_wb_reg_wdata_o, 100 + k); end
      tick();
      checks++;
      if (t_wb_count_o !== 3'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2 at step %0d", t_wb_count_o, k); end
    end
    offer(1'b0, 32'h0);
    for (int k = 110; k < 112; k++) begin
      checks++;
      if (t_wb_reg_wdata_o !== 32'(k)) begin errors++; $display("FAIL b2b_tail: got %0d expected %0d", t_wb_reg_wdata_o, k); end
      tick();
    end
    f_wb_ready_i = 1'b0;
    checks++;
    if (t_wb_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_empty: got valid %b expected 0", t_wb_valid_o); end
  endtask

  task automatic test_flush();
    f_wb_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'(200 + i));
      tick();
    end
    checks++;
    if (t_wb_count_o !== 3'd3) begin errors++; $display("FAIL flush_pre: got count %0d expected 3", t_wb_count_o); end
    f_flush_i = 1'b1;
    f_wb_ready_i = 1'b1;
    offer(1'b1, 32'd203);
    tick();
    f_flush_i = 1'b0;
    f_wb_ready_i = 1'b0;
    offer(1'b0, 32'h0);
    checks++;
    if ({t_wb_count_o, t_wb_valid_o, t_lsu_ready_o} !== {3'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL flush_state: got count=%0d valid=%b ready=%b expected 0/0/1",
                         t_wb_count_o, t_wb_valid_o, t_lsu_ready_o);
    end
    offer(1'b1, 32'd204);
    tick();
    offer(1'b0, 32'h0);
    checks++;
    if ({t_wb_count_o, t_wb_reg_wdata_o} !== {3'd1, 32'd204}) begin
      errors++; $display("FAIL flush_next: got count=%0d wdata=%0d expected 1/204", t_wb_count_o, t_wb_reg_wdata_o);
    end
    f_wb_ready_i = 1'b1;
    tick();
    f_wb_ready_i = 1'b0;
    checks++;
    if (t_wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drain: got valid %b expected 0", t_wb_valid_o); end
  endtask

  task automatic test_async_reset();
    f_wb_ready_i = 1'b0;
    offer(1'b1, 32'd300);
    tick();
    offer(1'b1, 32'd301);
    tick();
    offer(1'b0, 32'h0);
    checks++;
    if (t_wb_count_o !== 3'd2) begin errors++; $display("FAIL areset_pre: got count %0d expected 2", t_wb_count_o); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({t_wb_valid_o, t_wb_count_o, t_lsu_ready_o, t_wb_reg_wdata_o} !== {1'b0, 3'd0, 1'b1, 32'd0}) begin
      errors++; $display("FAIL areset_clear: got valid=%b count=%0d ready=%b wdata=%0d expected 0/0/1/0",
                         t_wb_valid_o, t_wb_count_o, t_lsu_ready_o, t_wb_reg_wdata_o);
    end
    #1;
    reset = 1'b0;
    tick();
    offer(1'b1, 32'd302);
    tick();
    offer(1'b0, 32'h0);
    checks++;
    if ({t_wb_count_o, t_wb_valid_o, t_wb_reg_wdata_o} !== {3'd1, 1'b1, 32'd302}) begin
      errors++; $display("FAIL areset_next: got count=%0d valid=%b wdata=%0d expected 1/1/302",
                         t_wb_count_o, t_wb_valid_o, t_wb_reg_wdata_o);
    end
    f_wb_ready_i = 1'b1;
    tick();
    f_wb_ready_i = 1'b0;
    checks++;
    if (t_wb_count_o !== 3'd0) begin errors++; $display("FAIL areset_drain: got count %0d expected 0", t_wb_count_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_lsu_wb_buf.md
# ysyx_23060025_lsu_wb_buf

Parametrised elastic buffer between the LSU and the write-back stage. It replaces the single-entry LSU/WB register with a DEPTH-entry FIFO and a full valid/ready handshake on both sides, so a WB stall does not stall the LSU until the buffer is full. It also provides a pipeline flush and an occupancy count. The buffer carries the full write-back payload: GPR write, CSR write, memory-instruction flag and ebreak flag.

## Interface
Parameters:
- DATA_WIDTH, 32, width of GPR and CSR write data
- DEPTH, 2, number of entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden)

Ports:
- clock  in  1  sole clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- f_lsu_valid_i  in  1  LSU offers a payload this cycle
- t_lsu_ready_o  out  1  buffer accepts a payload this cycle
- f_lsu_reg_wen_i  in  1  GPR write enable
- f_lsu_wreg_i  in  5  GPR index
- f_lsu_reg_wdata_i  in  DATA_WIDTH  GPR write data
- f_lsu_csr_wdata_i  in  DATA_WIDTH  CSR write data
- f_lsu_csr_type_i  in  3  CSR operation type
- f_lsu_memory_inst_i  in  1  instruction accessed memory
- f_lsu_ebreak_flag_i  in  1  instruction is ebreak
- f_flush_i  in  1  discard all buffered entries
- t_wb_valid_o  out  1  head entry valid
- f_wb_ready_i  in  1  WB consumes the head entry this cycle
- t_wb_reg_wen_o, t_wb_wreg_o, t_wb_reg_wdata_o, t_wb_csr_wdata_o, t_wb_csr_type_o, t_wb_memory_inst_o, t_wb_ebreak_flag_o  out  1/5/DATA_WIDTH/DATA_WIDTH/3/1/1  head-entry payload fields
- t_wb_count_o  out  CNT_W  number of occupied entries

## Operation
- Storage: DEPTH entries of 2*DATA_WIDTH+11 bits. Write and read pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Count is CNT_W bits wide.
- Push condition: f_lsu_valid_i & t_lsu_ready_o. The payload is written at the write pointer, and the write pointer increments.
- Pop condition: t_wb_valid_o & f_wb_ready_i. The read pointer increments.
- t_lsu_ready_o = (count != DEPTH). It is derived from registered state only, with no combinational path from f_wb_ready_i. A full buffer does not accept a push even when a pop happens in the same cycle.
- t_wb_valid_o = (count != 0).
- Payload outputs are driven from the head entry. When the buffer is empty they are forced to 0, so t_wb_reg_wen_o and t_wb_ebreak_flag_o never assert with valid low.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- Push and pop in the same cycle while not full and not empty are both legal and both take effect.
- Flush: on an edge with f_flush_i = 1, pointers and count go to 0. Flush dominates any push or pop in that cycle; the offered LSU payload is dropped even if t_lsu_ready_o was 1. Flush does not clear the storage array.
- Entries leave in exact arrival order. There is no bypass from input to output.

## Timing
- Reset (asynchronous, takes effect immediately):
  - pointers and count = 0
  - t_wb_valid_o = 0, all t_wb_* payload outputs = 0, t_wb_count_o = 0
  - t_lsu_ready_o = 1
- Reset asserted mid-operation discards all entries immediately, with no dependence on the clock.
- Latency: a payload pushed at edge N is visible on the outputs, with t_wb_valid_o = 1, after edge N. Minimum latency is 1 cycle.
- Throughput: 1 entry per cycle when WB keeps f_wb_ready_i high.
- Full boundary: after DEPTH pushes with no pops, t_lsu_ready_o = 0. It returns to 1 on the cycle after the first pop.
- Empty boundary: after the last pop, t_wb_valid_o = 0 from the next cycle.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no loss or duplication of entries.
- Flush: t_wb_valid_o = 0, t_wb_count_o = 0 and t_lsu_ready_o = 1 starting the cycle after the flush edge.

## Test plan
- Reset, then idle: t_lsu_ready_o = 1, t_wb_valid_o = 0, count = 0, all payload outputs 0.
- Single transfer: push wreg = 5, reg_wdata = 0xDEADBEEF, reg_wen = 1, with f_wb_ready_i = 1. The outputs show exactly this payload for one cycle starting the cycle after the push, then valid drops.
- Fill and drain with DEPTH = 4 and f_wb_ready_i = 0: push 4 entries with wdata 1..4. Count goes 1, 2, 3, 4 and ready = 0 after the fourth push; a fifth push offered while full is not accepted. Raise f_wb_ready_i: outputs are 1, 2, 3, 4 in order, then valid = 0.
- Simultaneous push/pop at count = 2 for 10 cycles with incrementing wdata: count stays 2, pointers wrap, and the output order is strictly increasing with no gaps.
- Flush with count = 3 while a push and a pop are offered in the same cycle: next cycle count = 0, valid = 0, ready = 1. No entry is popped by the flush-cycle pop, and the dropped push never appears at the output.
- Async reset pulsed between clock edges with count = 2: outputs clear immediately. After reset releases, the next push appears alone, 1 cycle later.
